// File: rtl/icache.sv
// Direct-mapped, one-word-per-line instruction cache sitting between the IF stage and mem_ctrl.
// Hits answer one cycle after acceptance; misses fetch the word through mem_ctrl's IF port.
module icache #(
  parameter int INDEX_W = 7,
  parameter int ADDR_W  = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rdy,
  input  logic              req_valid,
  input  logic [ADDR_W-1:0] req_pc,
  output logic              req_ready,
  output logic              inst_valid,
  output logic [31:0]       inst,
  output logic [ADDR_W-1:0] inst_pc,
  output logic              mc_enable,
  output logic [ADDR_W-1:0] mc_addr,
  input  logic [31:0]       mc_inst,
  input  logic              mc_finished
);

  localparam int LINES = 1 << INDEX_W;
  localparam int TAG_W = ADDR_W - INDEX_W - 2;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] MISS = 2'd1;
  localparam logic [1:0] RESP = 2'd2;

  logic [1:0]        state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic              inst_valid_q, inst_valid_d;
  logic [31:0]       inst_q, inst_d;
  logic [ADDR_W-1:0] inst_pc_q, inst_pc_d;
  logic              mc_enable_q, mc_enable_d;
  logic [ADDR_W-1:0] mc_addr_q, mc_addr_d;
  logic [LINES-1:0]  valid_q, valid_d;

  logic [TAG_W-1:0]  tag_mem  [LINES];
  logic [31:0]       data_mem [LINES];

  logic [INDEX_W-1:0] reqIndex;
  logic [TAG_W-1:0]   reqTag;
  logic [INDEX_W-1:0] pcIndex;
  logic [TAG_W-1:0]   pcTag;
  logic               reqHit;
  logic               fillNow;

  assign reqIndex = req_pc[INDEX_W+1:2];
  assign reqTag   = req_pc[ADDR_W-1:INDEX_W+2];
  assign pcIndex  = pc_q[INDEX_W+1:2];
  assign pcTag    = pc_q[ADDR_W-1:INDEX_W+2];
  assign reqHit   = valid_q[reqIndex] && (tag_mem[reqIndex] == reqTag);
  assign fillNow  = rdy && !rst && (state_q == MISS) && mc_finished;

  assign req_ready  = !rst && (state_q == IDLE);
  assign inst_valid = inst_valid_q;
  assign inst       = inst_q;
  assign inst_pc    = inst_pc_q;
  assign mc_enable  = mc_enable_q;
  assign mc_addr    = mc_addr_q;

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    inst_valid_d = 1'b0;
    inst_d       = inst_q;
    inst_pc_d    = inst_pc_q;
    mc_enable_d  = mc_enable_q;
    mc_addr_d    = mc_addr_q;
    valid_d      = valid_q;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          pc_d = req_pc;
          if (reqHit) begin
            inst_valid_d = 1'b1;
            inst_d       = data_mem[reqIndex];
            inst_pc_d    = req_pc;
          end else begin
            state_d     = MISS;
            mc_enable_d = 1'b1;
            mc_addr_d   = {req_pc[ADDR_W-1:2], 2'b00};
          end
        end
      end
      // mc_addr stays put until the fill lands; mem_ctrl restarts if it moves.
      MISS: begin
        if (mc_finished) begin
          valid_d[pcIndex] = 1'b1;
          mc_enable_d      = 1'b0;
          inst_valid_d     = 1'b1;
          inst_d           = mc_inst;
          inst_pc_d        = pc_q;
          state_d          = RESP;
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // rdy low freezes every register, so the whole update is gated by it.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      pc_q         <= '0;
      inst_valid_q <= 1'b0;
      inst_q       <= '0;
      inst_pc_q    <= '0;
      mc_enable_q  <= 1'b0;
      mc_addr_q    <= '0;
      valid_q      <= '0;
    end else if (rdy) begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      inst_valid_q <= inst_valid_d;
      inst_q       <= inst_d;
      inst_pc_q    <= inst_pc_d;
      mc_enable_q  <= mc_enable_d;
      mc_addr_q    <= mc_addr_d;
      valid_q      <= valid_d;
    end
  end

  always_ff @(posedge clk) begin
    if (fillNow) begin
      tag_mem[pcIndex]  <= pcTag;
      data_mem[pcIndex] <= mc_inst;
    end
  end

endmodule

// File: tb/tb_icache.sv
// Scoreboard bench for icache: a line-address model predicts hit/miss and data per request,
// a monitor pops predictions as responses and fills appear.
module tb_icache;

  logic        clk;
  logic        rst;
  logic        rdy;
  logic        req_valid;
  logic [31:0] req_pc;
  logic        req_ready;
  logic        inst_valid;
  logic [31:0] inst;
  logic [31:0] inst_pc;
  logic        mc_enable;
  logic [31:0] mc_addr;
  logic [31:0] mc_inst;
  logic        mc_finished;

  icache #(.INDEX_W(7), .ADDR_W(32)) dut (
    .clk         (clk),
    .rst         (rst),
    .rdy         (rdy),
    .req_valid   (req_valid),
    .req_pc      (req_pc),
    .req_ready   (req_ready),
    .inst_valid  (inst_valid),
    .inst        (inst),
    .inst_pc     (inst_pc),
    .mc_enable   (mc_enable),
    .mc_addr     (mc_addr),
    .mc_inst     (mc_inst),
    .mc_finished (mc_finished)
  );

  typedef struct {
    logic [31:0] pc;
    logic [31:0] data;
    bit          isMiss;
    int          acceptEdge;
  } expResp_t;

  typedef struct {
    logic [31:0] addr;
    int          acceptEdge;
  } expFill_t;

  expResp_t sbQ[$];
  expFill_t fillQ[$];

  bit          lineValid [128];
  int unsigned lineWord  [128];

  int vectors;
  int miscompares;
  int actEdges;
  bit autoMem;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] memWord(input logic [31:0] a);
    if (a == 32'h0) return 32'h0000_0013;
    if (a == 32'h4) return 32'h0010_0093;
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_5A5A;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    vectors++;
    if (actual !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
    end
  endtask

  task automatic resetModel();
    sbQ.delete();
    fillQ.delete();
    for (int i = 0; i < 128; i++) lineValid[i] = 1'b0;
  endtask

  // Counts clock edges on which the cache is allowed to advance.
  initial begin
    actEdges = 0;
    forever begin
      @(posedge clk);
      if (rdy) actEdges++;
    end
  end

  // Prediction side: every accepted request is classified against the line model.
  initial begin
    expResp_t    e;
    expFill_t    f;
    int unsigned w;
    int          idx;
    forever begin
      @(negedge clk);
      if (!rst && rdy && req_valid && req_ready) begin
        w            = req_pc >> 2;
        idx          = int'(w % 128);
        e.pc         = req_pc;
        e.data       = memWord({req_pc[31:2], 2'b00});
        e.acceptEdge = actEdges + 1;
        if (lineValid[idx] && lineWord[idx] == w) begin
          e.isMiss = 1'b0;
        end else begin
          e.isMiss       = 1'b1;
          lineValid[idx] = 1'b1;
          lineWord[idx]  = w;
          f.addr         = {req_pc[31:2], 2'b00};
          f.acceptEdge   = actEdges + 1;
          fillQ.push_back(f);
        end
        sbQ.push_back(e);
      end
    end
  end

  // Monitor: compares fill requests and responses against the queued predictions.
  initial begin
    expResp_t    e;
    expFill_t    f;
    logic        prevEn;
    logic [31:0] prevAddr;
    prevEn   = 1'b0;
    prevAddr = '0;
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (mc_enable && !prevEn) begin
          if (fillQ.size() == 0) begin
            checkOutput("fill_unexpected", {31'd0, mc_enable}, 32'd0);
          end else begin
            f = fillQ.pop_front();
            checkOutput("fill_addr", mc_addr, f.addr);
            checkOutput("fill_start_edge", actEdges, f.acceptEdge);
          end
        end else if (mc_enable && prevEn && mc_addr != prevAddr) begin
          checkOutput("fill_addr_stable", mc_addr, prevAddr);
        end
        if (inst_valid && rdy) begin
          if (sbQ.size() == 0) begin
            checkOutput("resp_unexpected", {31'd0, inst_valid}, 32'd0);
          end else begin
            e = sbQ.pop_front();
            checkOutput("resp_inst", inst, e.data);
            checkOutput("resp_pc", inst_pc, e.pc);
            checkOutput("resp_mc_enable", {31'd0, mc_enable}, 32'd0);
            if (e.isMiss)
              checkOutput("miss_not_early", {31'd0, actEdges > e.acceptEdge}, 32'd1);
            else
              checkOutput("hit_latency", actEdges, e.acceptEdge);
          end
        end
      end
      prevEn   = mc_enable;
      prevAddr = mc_addr;
    end
  end

  // mem_ctrl stand-in: random latency, plus stray mc_finished pulses while idle.
  initial begin
    int  countdown;
    bit  inFill;
    countdown = 0;
    inFill    = 1'b0;
    forever begin
      @(negedge clk);
      if (autoMem) begin
        if (mc_enable) begin
          if (!inFill) begin
            inFill    = 1'b1;
            countdown = int'($urandom % 4);
          end
          if (countdown == 0) begin
            mc_finished = 1'b1;
            mc_inst     = memWord(mc_addr);
          end else begin
            countdown--;
            mc_finished = 1'b0;
          end
        end else begin
          inFill      = 1'b0;
          mc_finished = ($urandom % 10) == 0;
          mc_inst     = $urandom;
        end
      end else begin
        inFill = 1'b0;
      end
    end
  end

  task automatic applyStimulus(input logic [31:0] pc);
    bit accepted;
    accepted  = 1'b0;
    req_pc    = pc;
    req_valid = 1'b1;
    for (int i = 0; i < 200 && !accepted; i++) begin
      @(negedge clk);
      if (req_ready && rdy && !rst) accepted = 1'b1;
    end
    if (!accepted) checkOutput("accept_timeout", pc, 32'hFFFF_FFFF);
    @(posedge clk);
    #1;
  endtask

  task automatic waitIdle();
    bit done;
    done = 1'b0;
    for (int i = 0; i < 300 && !done; i++) begin
      @(negedge clk);
      if (sbQ.size() == 0 && fillQ.size() == 0 && req_ready) done = 1'b1;
    end
    if (!done) checkOutput("idle_timeout", sbQ.size() + fillQ.size(), 32'd0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    autoMem     = 1'b1;
    rst         = 1'b1;
    rdy         = 1'b1;
    req_valid   = 1'b0;
    req_pc      = '0;
    mc_finished = 1'b0;
    mc_inst     = '0;
    resetModel();

    // Reset values
    repeat (3) @(posedge clk);
    #1;
    checkOutput("rst_req_ready", {31'd0, req_ready}, 32'd0);
    checkOutput("rst_inst_valid", {31'd0, inst_valid}, 32'd0);
    checkOutput("rst_inst", inst, 32'd0);
    checkOutput("rst_inst_pc", inst_pc, 32'd0);
    checkOutput("rst_mc_enable", {31'd0, mc_enable}, 32'd0);
    checkOutput("rst_mc_addr", mc_addr, 32'd0);
    rst = 1'b0;
    @(posedge clk);
    #1;
    checkOutput("post_rst_req_ready", {31'd0, req_ready}, 32'd1);

    // Cold miss on 0x0, then a hit on the same line
    applyStimulus(32'h0);
    req_valid = 1'b0;
    checkOutput("t1_mc_enable", {31'd0, mc_enable}, 32'd1);
    checkOutput("t1_mc_addr", mc_addr, 32'd0);
    waitIdle();
    applyStimulus(32'h0);
    req_valid = 1'b0;
    checkOutput("t2_no_fill", {31'd0, mc_enable}, 32'd0);
    waitIdle();

    // Back-to-back hits
    applyStimulus(32'h4);
    req_valid = 1'b0;
    waitIdle();
    applyStimulus(32'h4);
    applyStimulus(32'h0);
    applyStimulus(32'h4);
    req_valid = 1'b0;
    waitIdle();

    // Conflict eviction on index 0
    applyStimulus(32'h200);
    req_valid = 1'b0;
    waitIdle();
    applyStimulus(32'h0);
    req_valid = 1'b0;
    waitIdle();

    // rdy low freezes a pending miss even when mc_finished toggles
    autoMem     = 1'b0;
    mc_finished = 1'b0;
    applyStimulus(32'h300);
    req_valid = 1'b0;
    checkOutput("t5_en", {31'd0, mc_enable}, 32'd1);
    for (int k = 0; k < 3; k++) begin
      rdy         = 1'b0;
      mc_finished = (k % 2) == 0;
      mc_inst     = 32'hDEAD_BEEF;
      @(posedge clk);
      #1;
    end
    checkOutput("t5_frozen_en", {31'd0, mc_enable}, 32'd1);
    checkOutput("t5_frozen_valid", {31'd0, inst_valid}, 32'd0);
    checkOutput("t5_frozen_addr", mc_addr, 32'h300);
    rdy         = 1'b1;
    mc_finished = 1'b0;
    @(posedge clk);
    #1;
    checkOutput("t5_still_miss", {31'd0, mc_enable}, 32'd1);
    mc_finished = 1'b1;
    mc_inst     = memWord(32'h300);
    @(posedge clk);
    #1;
    mc_finished = 1'b0;
    checkOutput("t5_en_drop", {31'd0, mc_enable}, 32'd0);
    checkOutput("t5_resp_valid", {31'd0, inst_valid}, 32'd1);
    autoMem = 1'b1;
    waitIdle();

    // Reset mid-miss abandons the fill and invalidates every line
    autoMem     = 1'b0;
    mc_finished = 1'b0;
    applyStimulus(32'h400);
    req_valid = 1'b0;
    checkOutput("t6_en", {31'd0, mc_enable}, 32'd1);
    rst = 1'b1;
    resetModel();
    @(posedge clk);
    #1;
    checkOutput("t6_rst_en", {31'd0, mc_enable}, 32'd0);
    checkOutput("t6_rst_ready", {31'd0, req_ready}, 32'd0);
    rst     = 1'b0;
    autoMem = 1'b1;
    @(posedge clk);
    #1;
    applyStimulus(32'h400);
    req_valid = 1'b0;
    checkOutput("t6_refill", {31'd0, mc_enable}, 32'd1);
    waitIdle();
    applyStimulus(32'h402);
    req_valid = 1'b0;
    waitIdle();

    // Randomized traffic over a small set of conflicting lines with rdy stalls
    for (int c = 0; c < 1500; c++) begin
      rdy       = ($urandom % 5) != 0;
      req_valid = ($urandom % 10) < 7;
      req_pc    = (($urandom % 4) << 9) | (($urandom % 8) << 2) | ($urandom % 4);
      @(posedge clk);
      #1;
    end
    req_valid = 1'b0;
    rdy       = 1'b1;
    waitIdle();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
